// File: rtl/issue_scoreboard.sv
// issue_scoreboard: three-slot VLIW issue gate with per-register pending-write tracking,
// saturating stall counter, duplicate-destination flag and a drain/acknowledge handshake.
module issue_scoreboard #(
    parameter int NREG = 16,
    parameter int CNTW = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [3:0]      instpipe1,
    input  logic [3:0]      src1pipe1,
    input  logic [3:0]      src2pipe1,
    input  logic [3:0]      destpipe1,
    input  logic [3:0]      instpipe2,
    input  logic [3:0]      src1pipe2,
    input  logic [3:0]      src2pipe2,
    input  logic [3:0]      destpipe2,
    input  logic [3:0]      instpipe3,
    input  logic [3:0]      src1pipe3,
    input  logic [3:0]      src2pipe3,
    input  logic [3:0]      destpipe3,
    output logic            issue_ready,
    input  logic            w2r_wrpipe1,
    input  logic [3:0]      w2re_destpipe1,
    input  logic            w2r_wrpipe2,
    input  logic [3:0]      w2re_destpipe2,
    input  logic            w2r_wrpipe3,
    input  logic [3:0]      w2re_destpipe3,
    input  logic            drain_req,
    output logic            drain_ack,
    input  logic            flush,
    output logic [NREG-1:0] pending,
    output logic [4:0]      outstanding,
    output logic [CNTW-1:0] stall_cnt,
    output logic            err_dupdest
);
    typedef enum logic [1:0] {RUN, DRAIN, ACK} state_e;
    state_e          state_q, state_d;
    logic [NREG-1:0] pending_q, pending_d, set, clr;
    logic [4:0]      outstanding_q, outstanding_d;
    logic [CNTW-1:0] stall_q, stall_d;
    logic            err_q, err_d, dup;
    logic [3:0]      op [3];
    logic [3:0]      sa [3];
    logic [3:0]      sb [3];
    logic [3:0]      dd [3];
    logic [3:0]      wbd [3];
    logic            wbv [3];
    logic [2:0]      wr, rd1, rd2, haz;

    assign op  = '{instpipe1, instpipe2, instpipe3};
    assign sa  = '{src1pipe1, src1pipe2, src1pipe3};
    assign sb  = '{src2pipe1, src2pipe2, src2pipe3};
    assign dd  = '{destpipe1, destpipe2, destpipe3};
    assign wbd = '{w2re_destpipe1, w2re_destpipe2, w2re_destpipe3};
    assign wbv = '{w2r_wrpipe1, w2r_wrpipe2, w2r_wrpipe3};

    // Hazards look only at the registered vector; same-cycle writebacks never bypass.
    always_comb begin
        clr = '0;
        set = '0;
        wr  = '0;
        rd1 = '0;
        rd2 = '0;
        haz = '0;
        for (int i = 0; i < 3; i++) begin
            wr[i]  = op[i] != 4'd0;
            rd1[i] = wr[i] && op[i] != 4'd4;
            rd2[i] = wr[i] && !(op[i] inside {4'd4, 4'd5, 4'd6, 4'd11});
            haz[i] = (rd1[i] && pending_q[sa[i]]) || (rd2[i] && pending_q[sb[i]]) ||
                     (wr[i] && pending_q[dd[i]]);
            if (wbv[i]) clr[wbd[i]] = 1'b1;
        end
        issue_ready = issue_valid && state_q == RUN && !flush && haz == 3'b000;
        for (int i = 0; i < 3; i++)
            if (issue_ready && wr[i]) set[dd[i]] = 1'b1;
        pending_d = (pending_q & ~clr) | set;
        outstanding_d = '0;
        for (int i = 0; i < NREG; i++) outstanding_d = outstanding_d + 5'(pending_d[i]);
        dup = issue_ready && ((wr[0] && wr[1] && dd[0] == dd[1]) ||
                              (wr[0] && wr[2] && dd[0] == dd[2]) ||
                              (wr[1] && wr[2] && dd[1] == dd[2]));
        err_d   = err_q || dup;
        stall_d = (issue_valid && !issue_ready && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        state_d = state_q == RUN   ? (drain_req ? DRAIN : RUN) :
                  state_q == DRAIN ? (pending_q == '0 ? ACK : DRAIN) :
                                     (drain_req ? DRAIN : RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            pending_q     <= '0;
            outstanding_q <= '0;
            stall_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            stall_q       <= stall_d;
            err_q         <= err_d;
        end
    end

    assign pending     = pending_q;
    assign outstanding = outstanding_q;
    assign stall_cnt   = stall_q;
    assign err_dupdest = err_q;
    assign drain_ack   = state_q == ACK;
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed literal checks plus randomized traffic against a
// register-set reference model compared every cycle.
module tb_issue_scoreboard;
    localparam int CNTW = 8;
    localparam int SMAX = (1 << CNTW) - 1;

    logic clock = 1'b0, reset = 1'b1, issue_valid = 1'b0, drain_req = 1'b0, flush = 1'b0;
    logic [3:0] inst [3];
    logic [3:0] s1 [3];
    logic [3:0] s2 [3];
    logic [3:0] dst [3];
    logic [3:0] wd [3];
    logic       wr [3];
    logic issue_ready, drain_ack, err_dupdest;
    logic [15:0] pending;
    logic [4:0] outstanding;
    logic [CNTW-1:0] stall_cnt;
    int passed = 0, total = 0;

    issue_scoreboard #(.NREG(16), .CNTW(CNTW)) dut (
        .clock(clock), .reset(reset), .issue_valid(issue_valid),
        .instpipe1(inst[0]), .src1pipe1(s1[0]), .src2pipe1(s2[0]), .destpipe1(dst[0]),
        .instpipe2(inst[1]), .src1pipe2(s1[1]), .src2pipe2(s2[1]), .destpipe2(dst[1]),
        .instpipe3(inst[2]), .src1pipe3(s1[2]), .src2pipe3(s2[2]), .destpipe3(dst[2]),
        .issue_ready(issue_ready),
        .w2r_wrpipe1(wr[0]), .w2re_destpipe1(wd[0]),
        .w2r_wrpipe2(wr[1]), .w2re_destpipe2(wd[1]),
        .w2r_wrpipe3(wr[2]), .w2re_destpipe3(wd[2]),
        .drain_req(drain_req), .drain_ack(drain_ack), .flush(flush),
        .pending(pending), .outstanding(outstanding), .stall_cnt(stall_cnt),
        .err_dupdest(err_dupdest)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a set of in-flight registers and opcode class lookups.
    bit [15:0] mp = '0;
    int        mcnt = 0;
    bit        merr = 1'b0;
    int        mmode = 0;
    bit        ok = 1'b0;

    function automatic bit f_wr(logic [3:0] o); return o != 4'd0; endfunction
    function automatic bit f_r1(logic [3:0] o); return o != 4'd0 && o != 4'd4; endfunction
    function automatic bit f_r2(logic [3:0] o);
        return o inside {4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14, 4'd15};
    endfunction

    always @(negedge clock) begin
        bit haz, er, dupl;
        bit [15:0] np;
        haz = 1'b0;
        for (int i = 0; i < 3; i++)
            haz |= (f_r1(inst[i]) && mp[s1[i]]) || (f_r2(inst[i]) && mp[s2[i]]) ||
                   (f_wr(inst[i]) && mp[dst[i]]);
        er = issue_valid && mmode == 0 && !flush && !haz;
        if (ok) begin
            chk("m_ready", 32'(issue_ready), 32'(er));
            chk("m_pending", 32'(pending), 32'(mp));
            chk("m_outstanding", 32'(outstanding), 32'($countones(mp)));
            chk("m_stall", 32'(stall_cnt), 32'(mcnt));
            chk("m_err", 32'(err_dupdest), 32'(merr));
            chk("m_ack", 32'(drain_ack), 32'(mmode == 2));
        end
        if (reset) begin
            mp = '0; mcnt = 0; merr = 1'b0; mmode = 0; ok = 1'b1;
        end else begin
            np = mp;
            for (int i = 0; i < 3; i++) if (wr[i]) np[wd[i]] = 1'b0;
            dupl = 1'b0;
            if (er)
                for (int i = 0; i < 3; i++)
                    if (f_wr(inst[i])) begin
                        for (int j = 0; j < i; j++)
                            if (f_wr(inst[j]) && dst[j] == dst[i]) dupl = 1'b1;
                        np[dst[i]] = 1'b1;
                    end
            merr |= dupl;
            if (issue_valid && !er && mcnt < SMAX) mcnt++;
            case (mmode)
                0: mmode = drain_req ? 1 : 0;
                1: mmode = (mp == 0) ? 2 : 1;
                default: mmode = drain_req ? 1 : 0;
            endcase
            mp = np;
        end
    end

    task automatic idle();
        issue_valid = 0; drain_req = 0; flush = 0; reset = 0;
        for (int i = 0; i < 3; i++) begin
            inst[i] = 0; s1[i] = 0; s2[i] = 0; dst[i] = 0; wd[i] = 0; wr[i] = 0;
        end
    endtask

    task automatic nxt();
        @(posedge clock); #1; idle();
    endtask

    task automatic slot(input int n, input logic [3:0] o, a, b, d);
        inst[n] = o; s1[n] = a; s2[n] = b; dst[n] = d;
    endtask

    initial begin
        int dr;
        idle(); reset = 1;
        repeat (2) @(posedge clock);
        nxt();
        @(negedge clock);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_err", 32'(err_dupdest), 0);
        chk("rst_ack", 32'(drain_ack), 0);
        nxt(); issue_valid = 1; slot(0, 1, 1, 2, 3);
        @(negedge clock); chk("add_ready", 32'(issue_ready), 1);
        nxt();
        @(negedge clock); chk("add_pending", 32'(pending), 32'h8); chk("add_outst", 32'(outstanding), 1);
        nxt(); issue_valid = 1; slot(0, 2, 3, 4, 5);
        @(negedge clock); chk("raw_stall", 32'(issue_ready), 0);
        nxt(); issue_valid = 1; slot(0, 2, 3, 4, 5); wr[1] = 1; wd[1] = 3;
        @(negedge clock); chk("no_bypass", 32'(issue_ready), 0); chk("stall_1", 32'(stall_cnt), 1);
        nxt(); issue_valid = 1; slot(0, 2, 3, 4, 5);
        @(negedge clock);
        chk("wb_issue", 32'(issue_ready), 1); chk("stall_2", 32'(stall_cnt), 2);
        chk("wb_clear", 32'(pending), 0);
        nxt();
        @(negedge clock); chk("sub_pending", 32'(pending), 32'h20);
        nxt(); wr[0] = 1; wd[0] = 5;
        nxt(); issue_valid = 1; slot(0, 4, 0, 0, 1); slot(1, 4, 0, 0, 1);
        @(negedge clock); chk("dup_ready", 32'(issue_ready), 1);
        nxt();
        @(negedge clock); chk("dup_err", 32'(err_dupdest), 1); chk("dup_pending", 32'(pending), 32'h2);
        nxt(); issue_valid = 1; slot(0, 1, 0, 0, 7);
        @(negedge clock); chk("r7_ready", 32'(issue_ready), 1);
        nxt(); issue_valid = 1; slot(0, 4, 7, 0, 8);
        @(negedge clock); chk("load_src_ok", 32'(issue_ready), 1);
        nxt(); issue_valid = 1; slot(0, 5, 7, 0, 9);
        @(negedge clock); chk("move_stall", 32'(issue_ready), 0); chk("p182", 32'(pending), 32'h182);
        nxt(); wr[0] = 1; wd[0] = 1; wr[1] = 1; wd[1] = 7; wr[2] = 1; wd[2] = 8;
        nxt();
        @(negedge clock); chk("clr3", 32'(pending), 0); chk("err_sticky", 32'(err_dupdest), 1);
        nxt(); issue_valid = 1; slot(0, 1, 0, 0, 2); slot(1, 1, 0, 0, 9);
        @(negedge clock); chk("r2r9_ready", 32'(issue_ready), 1);
        nxt(); drain_req = 1;
        @(negedge clock); chk("p204", 32'(pending), 32'h204);
        nxt(); drain_req = 1; issue_valid = 1; slot(0, 1, 0, 0, 4); wr[0] = 1; wd[0] = 2;
        @(negedge clock); chk("drain_block", 32'(issue_ready), 0);
        nxt(); drain_req = 1; wr[0] = 1; wd[0] = 9;
        @(negedge clock); chk("drain_ack0", 32'(drain_ack), 0); chk("p200", 32'(pending), 32'h200);
        nxt();
        @(negedge clock); chk("drain_empty", 32'(pending), 0); chk("drain_ack1", 32'(drain_ack), 0);
        nxt();
        @(negedge clock); chk("drain_ack", 32'(drain_ack), 1);
        nxt(); issue_valid = 1; slot(0, 1, 0, 0, 4);
        @(negedge clock);
        chk("ack_once", 32'(drain_ack), 0); chk("run_ready", 32'(issue_ready), 1);
        chk("stall_4", 32'(stall_cnt), 4);
        repeat (300) begin nxt(); issue_valid = 1; slot(0, 1, 4, 0, 6); end
        @(negedge clock); chk("stall_sat", 32'(stall_cnt), SMAX);
        nxt(); drain_req = 1;
        nxt(); drain_req = 1;
        nxt(); drain_req = 1; reset = 1;
        @(negedge clock); chk("mid_drain", 32'(drain_ack), 0);
        nxt(); issue_valid = 1; slot(0, 1, 0, 0, 4);
        @(negedge clock);
        chk("r2_pending", 32'(pending), 0); chk("r2_outst", 32'(outstanding), 0);
        chk("r2_stall", 32'(stall_cnt), 0); chk("r2_err", 32'(err_dupdest), 0);
        chk("r2_ack", 32'(drain_ack), 0); chk("r2_ready", 32'(issue_ready), 1);
        dr = 0;
        repeat (3000) begin
            nxt();
            reset = $urandom_range(99) == 0;
            issue_valid = $urandom_range(9) < 7;
            flush = $urandom_range(9) == 0;
            for (int i = 0; i < 3; i++) begin
                inst[i] = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom);
                s1[i] = 4'($urandom); s2[i] = 4'($urandom); dst[i] = 4'($urandom);
                wr[i] = 1'($urandom_range(1)); wd[i] = 4'($urandom);
            end
            if (dr > 0) begin drain_req = 1; dr--; end
            else if ($urandom_range(39) == 0) dr = $urandom_range(6, 1);
        end
        nxt();
        @(negedge clock);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
